lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
- Load/store unit. It consumes the decoded memory controls (mem_wren, func3) and the ALU-computed address.
- It runs a request/acknowledge transaction on the data-memory bus. It stalls the core until the access completes.
- For stores, it performs byte-lane alignment. For loads, it performs sign/zero extension.
- It sits between the execute stage and data memory, on the memory side of the control decoder's func3/mem_wren outputs.

Parameters:
TIMEOUT_CYC, 255, cycles in REQ without bus_ack_i before aborting with err_o; 0 disables the timeout.

Ports:
clk_i  input  1  clock, rising edge
rst_ni  input  1  asynchronous active-low reset
req_i  input  1  memory access valid (load or store instruction in execute)
mem_wren_i  input  1  1 = store, 0 = load
func3_i  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
addr_i  input  32  byte address
st_data_i  input  32  store data, right-justified
ld_data_o  output  32  extended load result, valid when done_o=1
done_o  output  1  one-cycle pulse: access complete
err_o  output  1  one-cycle pulse: illegal func3, misaligned access, or timeout
stall_o  output  1  hold pipeline
bus_req_o  output  1  bus request
bus_we_o  output  1  bus write
bus_addr_o  output  32  word-aligned address (bits [1:0]=0)
bus_be_o  output  4  byte enables
bus_wdata_o  output  32  lane-aligned write data
bus_ack_i  input  1  bus acknowledge
bus_rdata_i  input  32  read data, valid with bus_ack_i

Behaviour:
- Reset (async, rst_ni=0):
  - State goes to IDLE immediately.
  - All outputs are 0, including bus_req_o. This applies mid-transaction; the bus must tolerate the dropped request.
  - The timeout counter clears to 0.
- States: IDLE, REQ, DONE, ERR.
- IDLE, when req_i=1, latches mem_wren_i, func3_i, addr_i and st_data_i, then:
  - Illegal: loads with func3 011/110/111, or stores with func3 other than 000/001/010 -> ERR.
  - Misaligned: H/HU with addr[0]=1, or W with addr[1:0]!=0 -> ERR.
  - Otherwise -> REQ.
- Output registering: bus_req_o, bus_we_o, bus_addr_o, bus_be_o and bus_wdata_o are registered. They are valid from the first REQ cycle and held stable until ack.
- Byte enables:
  - B: 0001<<addr[1:0]
  - H: 0011<<{addr[1],1'b0}
  - W: 1111
  - Loads use the same enables with bus_we_o=0.
- Write data:
  - B: byte replicated on all 4 lanes.
  - H: halfword replicated on both halves.
  - W: unchanged.
- REQ:
  - bus_ack_i=1 at a clock edge completes the transfer. bus_rdata_i is captured and extracted by addr[1:0], then sign-extended (B/H) or zero-extended (BU/HU). Next state is DONE, and bus_req_o deasserts.
  - If the counter reaches TIMEOUT_CYC (nonzero) without ack -> ERR, and bus_req_o drops.
- DONE: done_o=1 for exactly one cycle. ld_data_o holds the load result; for stores it is 0. Always -> IDLE; req_i is ignored in DONE.
- ERR: err_o=1 for exactly one cycle, ld_data_o=0, no bus transaction. Always -> IDLE.
- stall_o = (state==IDLE && req_i) || state==REQ. It is 0 in DONE/ERR, so the core advances on the done_o/err_o cycle.
- Latency: minimum 2 cycles from acceptance to done_o (ack in first REQ cycle). Each extra wait cycle adds one.
- ld_data_o holds its value until the next DONE or ERR.
- bus_ack_i outside REQ is ignored.
- Timeout counter saturates and clears on entering REQ.

Optional Feature:
- Macro: LSU_MISALIGN_SPLIT_EN.
- Defined: misaligned H/HU/W accesses with legal func3 are not errors. They split into two bus transactions:
  - First at addr&~3, with the low part of the enables.
  - Second at (addr&~3)+4, with the overflowed enables (e.g. W at addr 0x3: be 1000 then 0111).
  - Two additional states handle this: REQ2, and a one-cycle gap with bus_req_o=0 between the two requests.
  - Load bytes merge before extension.
  - done_o pulses once after the second ack.
  - A timeout on either transaction -> ERR. A store's first half may already be written.
- Undefined: misaligned accesses -> ERR as above.

Test Plan:
- LW addr 0x100, ack on first REQ cycle, rdata 0xDEADBEEF -> bus_addr 0x100, be 1111, done_o 2 cycles after accept, ld_data 0xDEADBEEF.
- LB addr 0x203, rdata 0x80FFFFFF -> be 1000, ld_data 0xFFFFFF80. LBU same access -> 0x00000080.
- SH addr 0x302, st_data 0x1234ABCD -> bus_we 1, be 1100, wdata 0xABCDABCD, ld_data 0, done_o pulse.
- LW addr 0x101 -> err_o one cycle after accept, no bus_req_o. With LSU_MISALIGN_SPLIT_EN: be 1110 then 0001, addrs 0x100/0x104, merged result.
- TIMEOUT_CYC=4, ack never -> bus_req_o high 4 cycles, then err_o pulse, stall_o released.
- rst_ni low during REQ -> bus_req_o, stall_o and state clear immediately; a new LW after release completes normally.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: byte-lane alignment, bus req/ack handshake, load extension.
// Optional LSU_MISALIGN_SPLIT_EN splits word-crossing accesses into two bus transfers.
module lsu_mem_ctrl #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        mem_wren_i,
  input  logic [2:0]  func3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] st_data_i,
  output logic [31:0] ld_data_o,
  output logic        done_o,
  output logic        err_o,
  output logic        stall_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYC > 0) ? CW'(TIMEOUT_CYC - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_DONE,
    S_ERR,
    S_GAP,
    S_REQ2
  } state_t;

  state_t state_q, state_d;

  logic          we_q;
  logic [2:0]    func3_q;
  logic [1:0]    off_q;
  logic [CW-1:0] cnt_q;
  logic          illegal, misaligned, timeout_hit;
  logic [3:0]    base_be, be_lo;
  logic [31:0]   wdata_rep, wdata_lo, ld_raw;

`ifdef LSU_MISALIGN_SPLIT_EN
  logic          split, split_q;
  logic [7:0]    be8;
  logic [63:0]   wd64;
  logic [3:0]    be_hi_q;
  logic [31:0]   wdata_hi_q, addr_hi_q, lo_q;
`endif

  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] raw);
    case (f3)
      3'b000:  extend = {{24{raw[7]}}, raw[7:0]};
      3'b001:  extend = {{16{raw[15]}}, raw[15:0]};
      3'b100:  extend = {24'b0, raw[7:0]};
      3'b101:  extend = {16'b0, raw[15:0]};
      default: extend = raw;
    endcase
  endfunction

  // Decode the incoming request into legality, lane enables and lane-aligned data
  always_comb begin
    if (mem_wren_i)
      illegal = !(func3_i == 3'b000 || func3_i == 3'b001 || func3_i == 3'b010);
    else
      illegal = (func3_i == 3'b011 || func3_i == 3'b110 || func3_i == 3'b111);
    misaligned = (func3_i[1:0] == 2'b01 && addr_i[0]) ||
                 (func3_i[1:0] == 2'b10 && addr_i[1:0] != 2'b00);
    case (func3_i[1:0])
      2'b00:   base_be = 4'b0001;
      2'b01:   base_be = 4'b0011;
      default: base_be = 4'b1111;
    endcase
    case (func3_i[1:0])
      2'b00:   wdata_rep = {4{st_data_i[7:0]}};
      2'b01:   wdata_rep = {2{st_data_i[15:0]}};
      default: wdata_rep = st_data_i;
    endcase
`ifdef LSU_MISALIGN_SPLIT_EN
    be8      = {4'b0000, base_be} << addr_i[1:0];
    wd64     = {32'b0, st_data_i} << {addr_i[1:0], 3'b000};
    be_lo    = be8[3:0];
    split    = |be8[7:4];
    wdata_lo = misaligned ? wd64[31:0] : wdata_rep;
`else
    be_lo    = base_be << addr_i[1:0];
    wdata_lo = wdata_rep;
`endif
  end

  assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_q == CNT_LAST);

`ifdef LSU_MISALIGN_SPLIT_EN
  assign ld_raw = split_q ? 32'({bus_rdata_i, lo_q} >> {off_q, 3'b000})
                          : bus_rdata_i >> {off_q, 3'b000};
`else
  assign ld_raw = bus_rdata_i >> {off_q, 3'b000};
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_i) begin
`ifdef LSU_MISALIGN_SPLIT_EN
          state_d = illegal ? S_ERR : S_REQ;
`else
          state_d = (illegal || misaligned) ? S_ERR : S_REQ;
`endif
        end
      end
      S_REQ: begin
        if (bus_ack_i) begin
`ifdef LSU_MISALIGN_SPLIT_EN
          state_d = split_q ? S_GAP : S_DONE;
`else
          state_d = S_DONE;
`endif
        end else if (timeout_hit) begin
          state_d = S_ERR;
        end
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      S_GAP:  state_d = S_REQ2;
      S_REQ2: begin
        if (bus_ack_i)        state_d = S_DONE;
        else if (timeout_hit) state_d = S_ERR;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Bus outputs are registered: loaded on entering a request state, cleared on leaving it
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_q        <= 1'b0;
      func3_q     <= '0;
      off_q       <= '0;
      cnt_q       <= '0;
      ld_data_o   <= '0;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_be_o    <= '0;
      bus_wdata_o <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
      split_q     <= 1'b0;
      be_hi_q     <= '0;
      wdata_hi_q  <= '0;
      addr_hi_q   <= '0;
      lo_q        <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_i) begin
            we_q    <= mem_wren_i;
            func3_q <= func3_i;
            off_q   <= addr_i[1:0];
            cnt_q   <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
            split_q    <= split;
            be_hi_q    <= be8[7:4];
            wdata_hi_q <= wd64[63:32];
            addr_hi_q  <= {addr_i[31:2], 2'b00} + 32'd4;
`endif
            if (state_d == S_REQ) begin
              bus_req_o   <= 1'b1;
              bus_we_o    <= mem_wren_i;
              bus_addr_o  <= {addr_i[31:2], 2'b00};
              bus_be_o    <= be_lo;
              bus_wdata_o <= wdata_lo;
            end else begin
              ld_data_o <= '0;
            end
          end
        end
        S_REQ, S_REQ2: begin
          if (state_d != state_q) begin
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_be_o    <= '0;
            bus_wdata_o <= '0;
            cnt_q       <= '0;
            if (state_d == S_DONE)
              ld_data_o <= we_q ? '0 : extend(func3_q, ld_raw);
            else if (state_d == S_ERR)
              ld_data_o <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
            if (state_d == S_GAP)
              lo_q <= bus_rdata_i;
`endif
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`ifdef LSU_MISALIGN_SPLIT_EN
        S_GAP: begin
          bus_req_o   <= 1'b1;
          bus_we_o    <= we_q;
          bus_addr_o  <= addr_hi_q;
          bus_be_o    <= be_hi_q;
          bus_wdata_o <= wdata_hi_q;
          cnt_q       <= '0;
        end
`endif
        default: ;
      endcase
    end
  end

  assign done_o  = (state_q == S_DONE);
  assign err_o   = (state_q == S_ERR);
  assign stall_o = rst_ni && ((state_q == S_IDLE && req_i) || state_q == S_REQ ||
                              state_q == S_GAP || state_q == S_REQ2);

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed self-checking bench for lsu_mem_ctrl (TIMEOUT_CYC=4).
module tb_lsu_mem_ctrl;

  logic        clk_i, rst_ni, req_i, mem_wren_i;
  logic [2:0]  func3_i;
  logic [31:0] addr_i, st_data_i, ld_data_o;
  logic        done_o, err_o, stall_o, bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i;
  logic [3:0]  bus_be_o;
  logic        bus_ack_i;

  int total = 0;
  int bad   = 0;

  int          r_lat, r_reqc, r_nreq;
  logic        r_done, r_err, r_we0;
  logic [31:0] r_ld, r_addr0, r_addr1, r_wd0;
  logic [3:0]  r_be0, r_be1;

  lsu_mem_ctrl #(.TIMEOUT_CYC(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .mem_wren_i(mem_wren_i),
    .func3_i(func3_i), .addr_i(addr_i), .st_data_i(st_data_i), .ld_data_o(ld_data_o),
    .done_o(done_o), .err_o(err_o), .stall_o(stall_o), .bus_req_o(bus_req_o),
    .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o), .bus_be_o(bus_be_o),
    .bus_wdata_o(bus_wdata_o), .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Issues one access and plays the bus slave; wait_cyc<0 means never acknowledge
  task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] st, input int wait_cyc,
                         input logic [31:0] rd0, input logic [31:0] rd1);
    logic prev;
    int   waited;
    @(posedge clk_i); #1;
    req_i = 1'b1; mem_wren_i = we; func3_i = f3; addr_i = addr; st_data_i = st;
    r_lat = 0; r_reqc = 0; r_nreq = 0; prev = 1'b0; waited = 0;
    r_addr0 = '0; r_addr1 = '0; r_be0 = '0; r_be1 = '0; r_wd0 = '0; r_we0 = 1'b0;
    @(posedge clk_i); #1;
    req_i = 1'b0; r_lat = 1;
    while (!done_o && !err_o && r_lat < 40) begin
      if (bus_req_o) begin
        if (!prev) begin
          if (r_nreq == 0) begin
            r_addr0 = bus_addr_o; r_be0 = bus_be_o; r_wd0 = bus_wdata_o; r_we0 = bus_we_o;
          end else begin
            r_addr1 = bus_addr_o; r_be1 = bus_be_o;
          end
          r_nreq++;
          waited = 0;
        end
        r_reqc++;
        bus_ack_i   = (wait_cyc >= 0) && (waited >= wait_cyc);
        bus_rdata_i = (r_nreq == 1) ? rd0 : rd1;
        waited++;
      end
      prev = bus_req_o;
      @(posedge clk_i); #1;
      r_lat++;
      bus_ack_i = 1'b0;
    end
    r_done = done_o;
    r_err  = err_o;
    r_ld   = ld_data_o;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; req_i = 1'b1; mem_wren_i = 1'b0; func3_i = 3'b010;
    addr_i = 32'h100; st_data_i = '0; bus_ack_i = 1'b0; bus_rdata_i = '0;
    #3;
    total++;
    if ({done_o, err_o, stall_o, bus_req_o, bus_we_o} !== 5'b0) begin
      bad++; $display("[TB] FAIL reset_ctrl got=%b exp=00000", {done_o, err_o, stall_o, bus_req_o, bus_we_o});
    end
    total++;
    if ({ld_data_o, bus_addr_o, bus_wdata_o, bus_be_o} !== 100'b0) begin
      bad++; $display("[TB] FAIL reset_data got=%h/%h/%h/%h exp=0", ld_data_o, bus_addr_o, bus_wdata_o, bus_be_o);
    end
    req_i = 1'b0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
  endtask

  task automatic test_lw();
    run_txn(1'b0, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF, 32'h0);
    total++;
    if (r_addr0 !== 32'h100 || r_be0 !== 4'b1111 || r_we0 !== 1'b0) begin
      bad++; $display("[TB] FAIL lw_bus got=%h/%b/%b exp=00000100/1111/0", r_addr0, r_be0, r_we0);
    end
    total++;
    if (r_lat !== 2 || r_done !== 1'b1) begin
      bad++; $display("[TB] FAIL lw_latency got=%0d done=%b exp=2 done=1", r_lat, r_done);
    end
    total++;
    if (r_ld !== 32'hDEADBEEF) begin
      bad++; $display("[TB] FAIL lw_data got=%h exp=deadbeef", r_ld);
    end
    total++;
    if (stall_o !== 1'b0 || bus_req_o !== 1'b0) begin
      bad++; $display("[TB] FAIL lw_release got stall=%b req=%b exp=0/0", stall_o, bus_req_o);
    end
    @(posedge clk_i); #1;
    total++;
    if (done_o !== 1'b0 || ld_data_o !== 32'hDEADBEEF) begin
      bad++; $display("[TB] FAIL lw_pulse_hold got done=%b ld=%h exp=0/deadbeef", done_o, ld_data_o);
    end
  endtask

  task automatic test_lb_lbu();
    run_txn(1'b0, 3'b000, 32'h203, 32'h0, 0, 32'h80FFFFFF, 32'h0);
    total++;
    if (r_be0 !== 4'b1000 || r_addr0 !== 32'h200) begin
      bad++; $display("[TB] FAIL lb_bus got=%b/%h exp=1000/00000200", r_be0, r_addr0);
    end
    total++;
    if (r_ld !== 32'hFFFFFF80) begin
      bad++; $display("[TB] FAIL lb_data got=%h exp=ffffff80", r_ld);
    end
    run_txn(1'b0, 3'b100, 32'h203, 32'h0, 0, 32'h80FFFFFF, 32'h0);
    total++;
    if (r_ld !== 32'h00000080) begin
      bad++; $display("[TB] FAIL lbu_data got=%h exp=00000080", r_ld);
    end
  endtask

  task automatic test_store();
    run_txn(1'b1, 3'b001, 32'h302, 32'h1234ABCD, 0, 32'hFFFFFFFF, 32'h0);
    total++;
    if (r_we0 !== 1'b1 || r_be0 !== 4'b1100 || r_addr0 !== 32'h300) begin
      bad++; $display("[TB] FAIL sh_bus got=%b/%b/%h exp=1/1100/00000300", r_we0, r_be0, r_addr0);
    end
    total++;
    if (r_wd0 !== 32'hABCDABCD) begin
      bad++; $display("[TB] FAIL sh_wdata got=%h exp=abcdabcd", r_wd0);
    end
    total++;
    if (r_done !== 1'b1 || r_ld !== 32'h0) begin
      bad++; $display("[TB] FAIL sh_done got done=%b ld=%h exp=1/0", r_done, r_ld);
    end
    run_txn(1'b1, 3'b000, 32'h001, 32'h0000005A, 0, 32'h0, 32'h0);
    total++;
    if (r_be0 !== 4'b0010 || r_wd0 !== 32'h5A5A5A5A) begin
      bad++; $display("[TB] FAIL sb_lanes got=%b/%h exp=0010/5a5a5a5a", r_be0, r_wd0);
    end
  endtask

  task automatic test_halfword_wait();
    run_txn(1'b0, 3'b001, 32'h202, 32'h0, 2, 32'h80011234, 32'h0);
    total++;
    if (r_lat !== 4 || r_reqc !== 3) begin
      bad++; $display("[TB] FAIL lh_wait got lat=%0d reqc=%0d exp=4/3", r_lat, r_reqc);
    end
    total++;
    if (r_ld !== 32'hFFFF8001 || r_be0 !== 4'b1100) begin
      bad++; $display("[TB] FAIL lh_data got=%h/%b exp=ffff8001/1100", r_ld, r_be0);
    end
    run_txn(1'b0, 3'b101, 32'h202, 32'h0, 1, 32'h80011234, 32'h0);
    total++;
    if (r_ld !== 32'h00008001 || r_lat !== 3) begin
      bad++; $display("[TB] FAIL lhu_data got=%h lat=%0d exp=00008001/3", r_ld, r_lat);
    end
  endtask

  task automatic test_misaligned();
    run_txn(1'b0, 3'b010, 32'h101, 32'h0, 0, 32'h44332211, 32'h88776655);
`ifdef LSU_MISALIGN_SPLIT_EN
    total++;
    if (r_be0 !== 4'b1110 || r_addr0 !== 32'h100 || r_be1 !== 4'b0001 || r_addr1 !== 32'h104) begin
      bad++; $display("[TB] FAIL lw_split_bus got=%b@%h %b@%h exp=1110@100 0001@104", r_be0, r_addr0, r_be1, r_addr1);
    end
    total++;
    if (r_done !== 1'b1 || r_lat !== 4 || r_ld !== 32'h55443322) begin
      bad++; $display("[TB] FAIL lw_split_data got done=%b lat=%0d ld=%h exp=1/4/55443322", r_done, r_lat, r_ld);
    end
`else
    total++;
    if (r_err !== 1'b1 || r_lat !== 1 || r_reqc !== 0) begin
      bad++; $display("[TB] FAIL lw_misalign got err=%b lat=%0d reqc=%0d exp=1/1/0", r_err, r_lat, r_reqc);
    end
    total++;
    if (r_ld !== 32'h0 || stall_o !== 1'b0) begin
      bad++; $display("[TB] FAIL lw_misalign_out got ld=%h stall=%b exp=0/0", r_ld, stall_o);
    end
`endif
    @(posedge clk_i); #1;
    total++;
    if (err_o !== 1'b0 || done_o !== 1'b0) begin
      bad++; $display("[TB] FAIL misalign_pulse got err=%b done=%b exp=0/0", err_o, done_o);
    end
  endtask

  task automatic test_illegal();
    run_txn(1'b0, 3'b011, 32'h100, 32'h0, 0, 32'h0, 32'h0);
    total++;
    if (r_err !== 1'b1 || r_reqc !== 0) begin
      bad++; $display("[TB] FAIL ld_f3_011 got err=%b reqc=%0d exp=1/0", r_err, r_reqc);
    end
    run_txn(1'b1, 3'b100, 32'h100, 32'h0, 0, 32'h0, 32'h0);
    total++;
    if (r_err !== 1'b1 || r_reqc !== 0) begin
      bad++; $display("[TB] FAIL st_f3_100 got err=%b reqc=%0d exp=1/0", r_err, r_reqc);
    end
    run_txn(1'b1, 3'b010, 32'h102, 32'hAABBCCDD, 0, 32'h0, 32'h0);
`ifdef LSU_MISALIGN_SPLIT_EN
    total++;
    if (r_done !== 1'b1 || r_be0 !== 4'b1100 || r_be1 !== 4'b0011 || r_wd0 !== 32'hCCDD0000) begin
      bad++; $display("[TB] FAIL sw_split got done=%b be=%b/%b wd=%h exp=1/1100/0011/ccdd0000", r_done, r_be0, r_be1, r_wd0);
    end
`else
    total++;
    if (r_err !== 1'b1 || r_reqc !== 0) begin
      bad++; $display("[TB] FAIL sw_misalign got err=%b reqc=%0d exp=1/0", r_err, r_reqc);
    end
`endif
  endtask

  task automatic test_timeout();
    run_txn(1'b0, 3'b010, 32'h400, 32'h0, -1, 32'h0, 32'h0);
    total++;
    if (r_reqc !== 4 || r_err !== 1'b1 || r_lat !== 5) begin
      bad++; $display("[TB] FAIL timeout got reqc=%0d err=%b lat=%0d exp=4/1/5", r_reqc, r_err, r_lat);
    end
    total++;
    if (stall_o !== 1'b0 || bus_req_o !== 1'b0 || r_ld !== 32'h0) begin
      bad++; $display("[TB] FAIL timeout_release got stall=%b req=%b ld=%h exp=0/0/0", stall_o, bus_req_o, r_ld);
    end
  endtask

  task automatic test_reset_mid_txn();
    @(posedge clk_i); #1;
    req_i = 1'b1; mem_wren_i = 1'b0; func3_i = 3'b010; addr_i = 32'h500;
    @(posedge clk_i); #1;
    req_i = 1'b0;
    total++;
    if (bus_req_o !== 1'b1 || stall_o !== 1'b1) begin
      bad++; $display("[TB] FAIL midrst_pre got req=%b stall=%b exp=1/1", bus_req_o, stall_o);
    end
    rst_ni = 1'b0;
    #1;
    total++;
    if (bus_req_o !== 1'b0 || stall_o !== 1'b0 || bus_be_o !== 4'b0 || bus_addr_o !== 32'h0) begin
      bad++; $display("[TB] FAIL midrst_clear got req=%b stall=%b be=%b addr=%h exp=0/0/0/0", bus_req_o, stall_o, bus_be_o, bus_addr_o);
    end
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    run_txn(1'b0, 3'b010, 32'h600, 32'h0, 0, 32'hCAFEF00D, 32'h0);
    total++;
    if (r_done !== 1'b1 || r_lat !== 2 || r_ld !== 32'hCAFEF00D || r_addr0 !== 32'h600) begin
      bad++; $display("[TB] FAIL midrst_after got done=%b lat=%0d ld=%h addr=%h exp=1/2/cafef00d/600", r_done, r_lat, r_ld, r_addr0);
    end
  endtask

  task automatic test_ack_ignored();
    @(posedge clk_i); #1;
    bus_ack_i = 1'b1; bus_rdata_i = 32'h12345678;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    bus_ack_i = 1'b0;
    total++;
    if (done_o !== 1'b0 || err_o !== 1'b0 || bus_req_o !== 1'b0 || ld_data_o !== 32'hCAFEF00D) begin
      bad++; $display("[TB] FAIL idle_ack got done=%b err=%b req=%b ld=%h exp=0/0/0/cafef00d", done_o, err_o, bus_req_o, ld_data_o);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_lb_lbu();
    test_store();
    test_halfword_wait();
    test_misaligned();
    test_illegal();
    test_timeout();
    test_reset_mid_txn();
    test_ack_ignored();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
